crc24b_attach: RTL and testbench
================================

Name: crc24b_attach

Overview:
Upstream neighbour of the turbo interleaver.
- Accepts one code-block payload bit-serially from segmentation and buffers it.
- Computes the LTE CRC24B over the payload.
- Replays the block as a contiguous K-bit stream (payload followed by 24 CRC bits) using the interleaver's vld_crc/cbs/data handshake.
- Absorbs upstream gaps so the interleaver always receives an unbroken burst.

Parameters:
K_SMALL, 1056, block size selected by cbs=0 (payload = K_SMALL-24 = 1032 bits)
K_LARGE, 6144, block size selected by cbs=1 (payload = 6120 bits)
CRC_W, 24, CRC length
POLY, 24'h800063, gCRC24B = D^24+D^23+D^6+D^5+D+1, low 24 bits

Ports:
clk  in  1  single clock; all logic is rising-edge
reset  in  1  asynchronous, active-low reset
in_vld  in  1  upstream bit valid
in_bit  in  1  payload bit, first-in = first-out
in_sob  in  1  start of block, qualifies the first bit together with in_vld
in_cbs  in  1  block size select, sampled with the in_sob bit
in_rdy  out  1  block can accept a bit this cycle
rdy_crc  in  1  interleaver ready for a new block
vld_crc  out  1  one-cycle block-start pulse to interleaver
cbs  out  1  block size of the block being sent
data_out  out  1  serial bit to interleaver
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; CRC register and counters are cleared.
  - vld_crc=0, cbs=0, data_out=0, in_rdy=0, busy=0.
  - in_rdy rises on the first clock edge after reset is released.
- Transfer rule: a bit transfers on a rising edge when in_vld && in_rdy.
- States: IDLE, LOAD, WAIT_RDY, HDR, SEND.
- IDLE (in_rdy=1):
  - Transfers without in_sob are dropped.
  - A transfer with in_sob stores bit 0, latches in_cbs, and moves to LOAD with count=1.
- LOAD (in_rdy=1):
  - Each transfer stores the bit at address count, then count increments.
  - CRC update per bit: fb = crc[23]^bit; crc = {crc[22:0],1'b0} ^ (fb ? POLY : 0). Initial value is 0.
  - When count reaches P = K-24, go to WAIT_RDY with in_rdy=0 from the next cycle.
  - A transfer with in_sob in LOAD aborts the current block and restarts it: count=1, CRC restarted with this bit, in_cbs re-latched.
  - Gaps (in_vld=0) of any length are allowed.
- WAIT_RDY (in_rdy=0): the state holds until rdy_crc=1 is sampled, then goes to HDR.
- HDR (exactly one cycle):
  - vld_crc=1; cbs drives the latched size.
  - cbs holds this value until the next HDR.
- SEND (exactly K consecutive cycles, no stalls, rdy_crc ignored):
  - Cycles 0..P-1: data_out = buffer[0..P-1].
  - Cycles P..K-1: data_out = crc[23] down to crc[0], MSB first.
  - After the last bit, go to IDLE; data_out=0 whenever not in SEND.
- Latency: the first data_out bit appears 1 cycle after vld_crc.
  - From the last input transfer to vld_crc: 2 cycles minimum, with rdy_crc high.
- Storage: 6120x1-bit buffer, 13-bit counters; unused depth is ignored when cbs=0.
- in_cbs is ignored on non-sob transfers.
- Reset asserted mid-LOAD or mid-SEND discards the block immediately. No partial burst resumes after reset is released.

Test Plan:
1. Reset, then cbs=0, 1032 zero bits with in_vld continuous, rdy_crc=1 -> one vld_crc pulse, cbs=0, then 1056 zeros on data_out; busy falls after the last bit.
2. cbs=0 payload all zero except bit 1031=1 -> data_out bit 1031=1, bits 1032..1055 = 0x800063 MSB first (1000_0000_0000_0000_0110_0011).
3. Random 1032-bit payload with random in_vld gaps (30% idle), rdy_crc held low 50 cycles after load -> in_rdy=0 and no vld_crc while waiting; 1056 contiguous bits whose CRC matches a bench model and whose total remainder is 0.
4. cbs=1, 6120 random bits -> vld_crc with cbs=1; 6144 contiguous bits; CRC matches the model.
5. Second in_sob after 500 bits mid-LOAD, then 1032 new bits -> only the second block is emitted, CRC over the second block only.
6. reset=0 at SEND cycle 300, released 5 cycles later -> data_out=0, vld_crc=0, busy=0 during and after reset; in_rdy=1 one cycle after release; next block is correct.

Source files
------------

// File: rtl/crc24b_attach.sv
// Buffers one bit-serial code-block payload, appends the LTE CRC24B and replays it as a K-bit burst.
// Latency: vld_crc one cycle after the load completes with rdy_crc high, first data bit one cycle after vld_crc.
// Backpressure: in_rdy drops once the payload is complete; the SEND burst never stalls.
module crc24b_attach #(
    parameter int                K_SMALL = 1056,
    parameter int                K_LARGE = 6144,
    parameter int                CRC_W   = 24,
    parameter logic [CRC_W-1:0]  POLY    = 24'h800063
) (
    input  logic clk,
    input  logic reset,
    input  logic in_vld,
    input  logic in_bit,
    input  logic in_sob,
    input  logic in_cbs,
    output logic in_rdy,
    input  logic rdy_crc,
    output logic vld_crc,
    output logic cbs,
    output logic data_out,
    output logic busy
);
    localparam int CNT_W = 13;
    localparam int P_MAX = K_LARGE - CRC_W;
    localparam logic [CNT_W-1:0] P_SMALL_C = CNT_W'(K_SMALL - CRC_W);
    localparam logic [CNT_W-1:0] P_LARGE_C = CNT_W'(K_LARGE - CRC_W);
    localparam logic [CNT_W-1:0] K_SMALL_C = CNT_W'(K_SMALL);
    localparam logic [CNT_W-1:0] K_LARGE_C = CNT_W'(K_LARGE);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, HDR, SEND} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               blk_cbs_q, blk_cbs_d;
    logic               cbs_q, cbs_d;
    logic               in_rdy_q, in_rdy_d;

    logic               mem [0:P_MAX-1];
    logic               wr_en;
    logic [CNT_W-1:0]   wr_addr;
    logic [CNT_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   p_len;
    logic [CNT_W-1:0]   k_len;
    logic               xfer;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    assign xfer  = in_vld && in_rdy_q;
    assign p_len = blk_cbs_q ? P_LARGE_C : P_SMALL_C;
    assign k_len = blk_cbs_q ? K_LARGE_C : K_SMALL_C;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        blk_cbs_d = blk_cbs_q;
        cbs_d     = cbs_q;
        wr_en     = 1'b0;
        wr_addr   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer && in_sob) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    blk_cbs_d = in_cbs;
                    cnt_d     = CNT_W'(1);
                    crc_d     = crc_step('0, in_bit);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    // A new start-of-block abandons whatever was partially loaded.
                    if (in_sob) begin
                        wr_addr   = '0;
                        blk_cbs_d = in_cbs;
                        cnt_d     = CNT_W'(1);
                        crc_d     = crc_step('0, in_bit);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        crc_d = crc_step(crc_q, in_bit);
                        if (cnt_d == p_len) begin
                            state_d = WAIT_RDY;
                        end
                    end
                end
            end
            WAIT_RDY: begin
                if (rdy_crc) begin
                    cbs_d   = blk_cbs_q;
                    cnt_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                state_d = SEND;
            end
            SEND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q >= p_len) begin
                    crc_d = {crc_q[CRC_W-2:0], 1'b0};
                end
                if (cnt_q == k_len - CNT_W'(1)) begin
                    cnt_d   = '0;
                    crc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_rdy_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            crc_q     <= '0;
            blk_cbs_q <= 1'b0;
            cbs_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            blk_cbs_q <= blk_cbs_d;
            cbs_q     <= cbs_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

    // Payload storage carries no reset; stale contents are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_bit;
        end
    end

    assign rd_addr = (cnt_q < P_LARGE_C) ? cnt_q : '0;

    always_comb begin
        data_out = 1'b0;
        if (state_q == SEND) begin
            data_out = (cnt_q < p_len) ? mem[rd_addr] : crc_q[CRC_W-1];
        end
    end

    assign in_rdy  = in_rdy_q;
    assign vld_crc = (state_q == HDR);
    assign cbs     = cbs_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_crc24b_attach.sv
// Bench for crc24b_attach: vector table of whole blocks plus hand-written abort, drop and reset sequences.
module tb_crc24b_attach;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_vld = 1'b0, in_bit = 1'b0, in_sob = 1'b0, in_cbs = 1'b0;
    logic in_rdy, rdy_crc = 1'b0, vld_crc, cbs, data_out, busy;

    int tests = 0;
    int failed = 0;
    bit payload [0:6119];
    bit got [0:6143];
    bit cur_cbs;

    localparam logic [24:0] GPOLY = 25'h1800063;

    crc24b_attach dut (
        .clk(clk), .reset(reset), .in_vld(in_vld), .in_bit(in_bit), .in_sob(in_sob),
        .in_cbs(in_cbs), .in_rdy(in_rdy), .rdy_crc(rdy_crc), .vld_crc(vld_crc),
        .cbs(cbs), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        bit           cbs_sel;
        int           kind;      // 0 zeros, 1 single one in last payload bit, 2 random
        int           gap_pct;
        int           rdy_hold;
        bit           use_model;
        logic [23:0]  exp_crc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Polynomial long division of payload(x)*x^24 by g(x).
    function automatic logic [23:0] model_crc(input int n);
        bit w [0:6167];
        logic [23:0] r;
        for (int i = 0; i < n + 24; i++) w[i] = (i < n) ? payload[i] : 1'b0;
        for (int i = 0; i < n; i++)
            if (w[i])
                for (int j = 0; j < 25; j++) w[i+j] ^= GPOLY[24-j];
        for (int k = 0; k < 24; k++) r[23-k] = w[n+k];
        return r;
    endfunction

    // Remainder of the whole received codeword divided by g(x).
    function automatic logic [23:0] codeword_rem(input int k_len);
        bit w [0:6143];
        logic [23:0] r;
        for (int i = 0; i < k_len; i++) w[i] = got[i];
        for (int i = 0; i + 24 < k_len; i++)
            if (w[i])
                for (int j = 0; j < 25; j++) w[i+j] ^= GPOLY[24-j];
        for (int k = 0; k < 24; k++) r[23-k] = w[k_len-24+k];
        return r;
    endfunction

    task automatic drive(input int n, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 4 * n + 200) begin
            @(posedge clk); #1;
            if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                in_vld = 1'b0;
                in_bit = 1'($urandom_range(1, 0));
                in_sob = 1'b0;
            end else begin
                in_vld = 1'b1;
                in_bit = payload[idx];
                in_sob = (idx == 0);
                in_cbs = (idx == 0) ? cur_cbs : 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            if (in_vld && in_rdy) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        in_sob = 1'b0;
        chk("load_bits_accepted", idx, n);
    endtask

    task automatic check_block(input int n, input bit exp_cbs, input logic [23:0] exp_crc);
        int k_len = n + 24;
        int cyc = 0;
        bit found = 1'b0;
        bit stray = 1'b0;
        int mism = 0;
        logic [23:0] crc_got;
        while (!found && cyc < 200) begin
            @(negedge clk);
            if (vld_crc) found = 1'b1;
            cyc++;
        end
        chk("vld_crc_seen", found, 1'b1);
        if (!found) return;
        chk("hdr_cbs", cbs, exp_cbs);
        for (int i = 0; i < k_len; i++) begin
            @(negedge clk);
            got[i] = data_out;
            if (vld_crc || !busy || in_rdy) stray = 1'b1;
        end
        for (int i = 0; i < n; i++) if (got[i] != payload[i]) mism++;
        for (int k = 0; k < 24; k++) crc_got[23-k] = got[n+k];
        chk("send_contiguous", stray, 1'b0);
        chk("payload_bits", mism, 0);
        chk("crc_field", crc_got, exp_crc);
        chk("codeword_rem", codeword_rem(k_len), 24'h0);
        @(negedge clk);
        chk("idle_after_send", {busy, data_out, cbs}, {1'b0, 1'b0, exp_cbs});
    endtask

    task automatic fill(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: payload[i] = 1'b0;
                1: payload[i] = (i == n - 1);
                default: payload[i] = 1'($urandom_range(1, 0));
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n = v.cbs_sel ? 6120 : 1032;
        bit waited_bad = 1'b0;
        logic [23:0] exp;
        fill(n, v.kind);
        exp = v.use_model ? model_crc(n) : v.exp_crc;
        cur_cbs = v.cbs_sel;
        rdy_crc = (v.rdy_hold == 0);
        drive(n, v.gap_pct);
        if (v.rdy_hold > 0) begin
            repeat (v.rdy_hold) begin
                @(negedge clk);
                if (vld_crc || in_rdy || !busy) waited_bad = 1'b1;
            end
            chk("wait_rdy_hold", waited_bad, 1'b0);
            @(posedge clk); #1;
            rdy_crc = 1'b1;
        end
        check_block(n, v.cbs_sel, exp);
    endtask

    vec_t vecs [5];

    initial begin
        bit bad;
        vecs[0] = '{cbs_sel: 1'b0, kind: 0, gap_pct: 0,  rdy_hold: 0,  use_model: 1'b0, exp_crc: 24'h000000};
        vecs[1] = '{cbs_sel: 1'b0, kind: 1, gap_pct: 0,  rdy_hold: 0,  use_model: 1'b0, exp_crc: 24'h800063};
        vecs[2] = '{cbs_sel: 1'b0, kind: 2, gap_pct: 30, rdy_hold: 50, use_model: 1'b1, exp_crc: 24'h0};
        vecs[3] = '{cbs_sel: 1'b1, kind: 2, gap_pct: 10, rdy_hold: 0,  use_model: 1'b1, exp_crc: 24'h0};
        vecs[4] = '{cbs_sel: 1'b1, kind: 1, gap_pct: 0,  rdy_hold: 5,  use_model: 1'b0, exp_crc: 24'h800063};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {in_rdy, vld_crc, cbs, data_out, busy}, 5'b0);
        reset = 1'b1;
        #1;
        chk("in_rdy_before_edge", in_rdy, 1'b0);
        @(negedge clk);
        chk("in_rdy_after_release", in_rdy, 1'b1);

        // Non-sob transfers in IDLE are discarded.
        @(posedge clk); #1;
        in_vld = 1'b1; in_sob = 1'b0; in_bit = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy) bad = 1'b1;
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk("idle_drop_no_sob", bad, 1'b0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Restart mid-load: only the second block is emitted.
        rdy_crc = 1'b1;
        cur_cbs = 1'b1;
        fill(500, 2);
        drive(500, 0);
        chk("busy_mid_load", busy, 1'b1);
        cur_cbs = 1'b0;
        fill(1032, 2);
        drive(1032, 20);
        check_block(1032, 1'b0, model_crc(1032));

        // Reset in the middle of SEND.
        fill(1032, 2);
        cur_cbs = 1'b1;
        fill(1032, 2);
        cur_cbs = 1'b0;
        drive(1032, 0);
        bad = 1'b1;
        for (int c = 0; c < 200 && bad; c++) begin
            @(negedge clk);
            if (vld_crc) bad = 1'b0;
        end
        chk("reset_case_vld", bad, 1'b0);
        repeat (301) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_async_outputs", {vld_crc, data_out, busy, in_rdy}, 4'b0);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (vld_crc || data_out || busy || in_rdy) bad = 1'b1;
        end
        chk("reset_held_outputs", bad, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("in_rdy_after_midsend_reset", in_rdy, 1'b1);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (vld_crc || data_out || busy) bad = 1'b1;
        end
        chk("no_resume_after_reset", bad, 1'b0);
        run_vec(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
